// File: rtl/bram_reg_master_pkg.sv
// Shared constants for the BRAM register bus master: opcodes, register offsets, address width.
// BRAM_REG_MASTER_POLL_EN adds the POLL state and its compare helper.
package bram_reg_master_pkg;

    localparam int BRAM_ADDR_WIDTH = 12;

    localparam logic [1:0] BRAM_OP_WRITE = 2'd0;
    localparam logic [1:0] BRAM_OP_READ  = 2'd1;
    localparam logic [1:0] BRAM_OP_POLL  = 2'd2;

    localparam logic [BRAM_ADDR_WIDTH-1:0] BRAM_ID_OFFSET      = 12'h000;
    localparam logic [BRAM_ADDR_WIDTH-1:0] BRAM_CONTROL_OFFSET = 12'h004;
    localparam logic [BRAM_ADDR_WIDTH-1:0] BRAM_STATUS_OFFSET  = 12'h008;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
`ifdef BRAM_REG_MASTER_POLL_EN
        , S_POLL
`endif
    } state_t;

`ifdef BRAM_REG_MASTER_POLL_EN
    function automatic logic poll_hit(
        input logic [31:0] data,
        input logic [31:0] expect_val,
        input logic [31:0] mask
    );
        return ((data ^ expect_val) & mask) == 32'h0;
    endfunction
`endif

endpackage

// File: rtl/bram_poll_timer.sv
// Poll read counter for bram_reg_master; expired flags that the current read is the last allowed.
// Only built when BRAM_REG_MASTER_POLL_EN is defined.
`ifdef BRAM_REG_MASTER_POLL_EN
module bram_poll_timer #(
    parameter int POLL_LIMIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(POLL_LIMIT + 1);

    logic [CW-1:0] count;

    assign expired = (count == CW'(POLL_LIMIT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/bram_reg_master.sv
// Single-command initiator for the BRAM control register bus (write, read, optional poll).
// BRAM_REG_MASTER_POLL_EN enables op 2 as a bounded poll; otherwise op 2 is illegal.
module bram_reg_master
    import bram_reg_master_pkg::*;
#(
    parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH,
    parameter int POLL_LIMIT = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [31:0]           cmd_mask,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [31:0]           wdata,
    input  logic [31:0]           rdata,
    output logic                  busy
);

    state_t state;
    logic   accept;

    assign accept = cmd_valid & cmd_ready;

`ifdef BRAM_REG_MASTER_POLL_EN
    logic [31:0] exp_q;
    logic [31:0] mask_q;
    logic        hit;
    logic        expired;

    assign hit = poll_hit(rdata, exp_q, mask_q);

    bram_poll_timer #(
        .POLL_LIMIT(POLL_LIMIT)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (accept),
        .inc    (state == S_POLL && !hit),
        .expired(expired)
    );
`else
    logic unused_mask;
    assign unused_mask = ^cmd_mask;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= 32'h0;
            resp_err   <= 1'b0;
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            reg_addr   <= '0;
            wdata      <= 32'h0;
            busy       <= 1'b0;
`ifdef BRAM_REG_MASTER_POLL_EN
            exp_q      <= 32'h0;
            mask_q     <= 32'h0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        unique case (1'b1)
                            (cmd_op == BRAM_OP_WRITE): begin
                                wr_en    <= 1'b1;
                                reg_addr <= cmd_addr;
                                wdata    <= cmd_wdata;
                                state    <= S_ACCESS;
                            end
                            (cmd_op == BRAM_OP_READ): begin
                                rd_en    <= 1'b1;
                                reg_addr <= cmd_addr;
                                state    <= S_ACCESS;
                            end
`ifdef BRAM_REG_MASTER_POLL_EN
                            (cmd_op == BRAM_OP_POLL): begin
                                rd_en    <= 1'b1;
                                reg_addr <= cmd_addr;
                                exp_q    <= cmd_wdata;
                                mask_q   <= cmd_mask;
                                state    <= S_POLL;
                            end
`endif
                            default: begin
                                resp_valid <= 1'b1;
                                resp_data  <= 32'h0;
                                resp_err   <= 1'b1;
                                state      <= S_RESP;
                            end
                        endcase
                    end
                end
                S_ACCESS: begin
                    wr_en      <= 1'b0;
                    rd_en      <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_data  <= rd_en ? rdata : 32'h0;
                    resp_err   <= 1'b0;
                    state      <= S_RESP;
                end
`ifdef BRAM_REG_MASTER_POLL_EN
                // A hit on the final allowed read still counts as success.
                S_POLL: begin
                    if (hit || expired) begin
                        rd_en      <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_data  <= rdata;
                        resp_err   <= !hit;
                        state      <= S_RESP;
                    end
                end
`endif
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        cmd_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_reg_master.sv
// Randomized self-checking bench for bram_reg_master with a register-file slave model.
// Poll scenarios run when BRAM_REG_MASTER_POLL_EN is defined; otherwise op 2 is checked as illegal.
module tb_bram_reg_master;
    import bram_reg_master_pkg::*;

    localparam int AW = BRAM_ADDR_WIDTH;
    localparam int PL = 16;

    logic          clk;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [31:0]   cmd_mask;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_data;
    logic          resp_err;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] reg_addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          busy;

    bram_reg_master #(
        .ADDR_WIDTH(AW),
        .POLL_LIMIT(PL)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_mask  (cmd_mask),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .reg_addr  (reg_addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Slave: ID register, status register that sets bit0 from read match_at on, plain RAM elsewhere.
    logic [31:0] mem [0:(1<<AW)-1];
    int status_reads = 0;
    int status_base  = 0;
    int match_at     = 0;
    int stat_n;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int both_cnt = 0;

    always_comb begin
        stat_n = status_reads - status_base + 1;
        rdata  = 32'h0;
        if (rd_en) begin
            if (reg_addr == BRAM_ID_OFFSET)
                rdata = 32'hABCD_1234;
            else if (reg_addr == BRAM_STATUS_OFFSET)
                rdata = {stat_n[30:0], (match_at != 0 && stat_n >= match_at)};
            else
                rdata = mem[reg_addr];
        end
    end

    always @(posedge clk) begin
        if (wr_en) mem[reg_addr] <= wdata;
        if (rd_en && reg_addr == BRAM_STATUS_OFFSET) status_reads <= status_reads + 1;
        wr_cnt = wr_cnt + int'(wr_en);
        rd_cnt = rd_cnt + int'(rd_en);
        if (wr_en && rd_en) both_cnt = both_cnt + 1;
    end

    logic [31:0] model_mem [int];
    logic [AW-1:0] waddrs [$];

    logic          wr1, rd1;
    logic [AW-1:0] a1;
    logic [31:0]   wd1;

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [31:0] wd, input logic [31:0] mk);
        int n;
        @(negedge clk);
        cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_mask = mk;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                wr1 = wr_en; rd1 = rd_en; a1 = reg_addr; wd1 = wdata;
            end
            if (resp_valid || lat >= 100) break;
        end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [31:0] wd, input logic [31:0] mk,
                        output int lat, output logic [31:0] d, output logic e,
                        output int nwr, output int nrd);
        int w0, r0;
        w0 = wr_cnt; r0 = rd_cnt;
        issue(op, a, wd, mk);
        wait_resp(lat);
        d = resp_data; e = resp_err;
        finish_resp();
        nwr = wr_cnt - w0; nrd = rd_cnt - r0;
    endtask

    task automatic test_reset();
        logic [31:0] obs [9];
        logic [31:0] req [9];
        obs = '{32'(cmd_ready), 32'(resp_valid), 32'(wr_en), 32'(rd_en), 32'(busy),
                32'(reg_addr), wdata, resp_data, 32'(resp_err)};
        req = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (obs[i] !== req[i])
                $display("FAIL reset_out%0d got %h want %h", i, obs[i], req[i]);
            else passed++;
        end
    endtask

    task automatic test_write();
        int lat, nwr, nrd;
        logic [31:0] d, wd;
        logic e;
        logic [AW-1:0] a;
        for (int i = 0; i < 6; i++) begin
            a  = (i == 0) ? BRAM_CONTROL_OFFSET : AW'($urandom_range(16, (1<<AW)-1));
            wd = (i == 0) ? 32'h0000_0055 : $urandom;
            send(BRAM_OP_WRITE, a, wd, $urandom, lat, d, e, nwr, nrd);
            model_mem[int'(a)] = wd;
            waddrs.push_back(a);
            checks++; if (lat !== 2) $display("FAIL wr_lat got %0d want 2", lat); else passed++;
            checks++; if (nwr !== 1) $display("FAIL wr_pulses got %0d want 1", nwr); else passed++;
            checks++; if (nrd !== 0) $display("FAIL wr_rd_pulses got %0d want 0", nrd); else passed++;
            checks++; if (wr1 !== 1'b1) $display("FAIL wr_at_t1 got %b want 1", wr1); else passed++;
            checks++; if (a1 !== a) $display("FAIL wr_addr got %h want %h", a1, a); else passed++;
            checks++; if (wd1 !== wd) $display("FAIL wr_data got %h want %h", wd1, wd); else passed++;
            checks++; if (d !== 32'h0) $display("FAIL wr_resp_data got %h want 0", d); else passed++;
            checks++; if (e !== 1'b0) $display("FAIL wr_resp_err got %b want 0", e); else passed++;
        end
    endtask

    task automatic test_read();
        int lat, nwr, nrd;
        logic [31:0] d, want;
        logic e;
        logic [AW-1:0] a;
        for (int i = 0; i < 6; i++) begin
            a    = (i == 0) ? BRAM_ID_OFFSET : waddrs[$urandom_range(0, waddrs.size()-1)];
            want = (i == 0) ? 32'hABCD_1234 : model_mem[int'(a)];
            send(BRAM_OP_READ, a, $urandom, $urandom, lat, d, e, nwr, nrd);
            checks++; if (lat !== 2) $display("FAIL rd_lat got %0d want 2", lat); else passed++;
            checks++; if (nrd !== 1) $display("FAIL rd_pulses got %0d want 1", nrd); else passed++;
            checks++; if (nwr !== 0) $display("FAIL rd_wr_pulses got %0d want 0", nwr); else passed++;
            checks++; if (rd1 !== 1'b1) $display("FAIL rd_at_t1 got %b want 1", rd1); else passed++;
            checks++; if (d !== want) $display("FAIL rd_data got %h want %h", d, want); else passed++;
            checks++; if (e !== 1'b0) $display("FAIL rd_err got %b want 0", e); else passed++;
        end
    endtask

    task automatic test_illegal();
        int lat, nwr, nrd;
        logic [31:0] d;
        logic e;
        logic [1:0] ops [2];
`ifdef BRAM_REG_MASTER_POLL_EN
        ops = '{2'd3, 2'd3};
`else
        ops = '{2'd3, 2'd2};
`endif
        for (int i = 0; i < 2; i++) begin
            send(ops[i], waddrs[0], $urandom, $urandom, lat, d, e, nwr, nrd);
            checks++; if (lat !== 1) $display("FAIL ill_lat got %0d want 1", lat); else passed++;
            checks++; if (nwr + nrd !== 0) $display("FAIL ill_strobes got %0d want 0", nwr + nrd); else passed++;
            checks++; if (d !== 32'h0) $display("FAIL ill_data got %h want 0", d); else passed++;
            checks++; if (e !== 1'b1) $display("FAIL ill_err got %b want 1", e); else passed++;
        end
    endtask

    task automatic test_backpressure();
        int lat, bad, w0, r0;
        logic [31:0] d0, want;
        logic [AW-1:0] a;
        a    = waddrs[$urandom_range(0, waddrs.size()-1)];
        want = model_mem[int'(a)];
        issue(BRAM_OP_READ, a, 32'h0, 32'h0);
        wait_resp(lat);
        d0 = resp_data;
        w0 = wr_cnt; r0 = rd_cnt; bad = 0;
        cmd_op = BRAM_OP_WRITE; cmd_addr = a; cmd_wdata = ~want; cmd_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_data !== d0 || cmd_ready !== 1'b0 || busy !== 1'b1)
                bad++;
        end
        cmd_valid = 1'b0;
        checks++; if (bad !== 0) $display("FAIL bp_stable got %0d bad cycles want 0", bad); else passed++;
        checks++; if (wr_cnt + rd_cnt - w0 - r0 !== 0)
            $display("FAIL bp_strobes got %0d want 0", wr_cnt + rd_cnt - w0 - r0); else passed++;
        checks++; if (d0 !== want) $display("FAIL bp_data got %h want %h", d0, want); else passed++;
        finish_resp();
        checks++; if ({resp_valid, cmd_ready, busy} !== 3'b010)
            $display("FAIL bp_after got %b want 010", {resp_valid, cmd_ready, busy}); else passed++;
    endtask

`ifdef BRAM_REG_MASTER_POLL_EN
    task automatic test_poll();
        int lat, nwr, nrd, n;
        logic [31:0] d, mk, want_d;
        logic e, hit;
        int pat [5];
        pat = '{5, 0, -1, $urandom_range(1, PL), PL};
        for (int i = 0; i < 5; i++) begin
            match_at = (pat[i] < 0) ? 0 : pat[i];
            mk = (pat[i] < 0) ? 32'h0 : 32'h1;
            // Model: first read whose bit0 matches under mask, else the PL-th read.
            if (mk == 32'h0) n = 1;
            else if (match_at == 0) n = PL;
            else n = match_at;
            hit = (mk == 32'h0) || (match_at != 0);
            want_d = (32'(n) << 1) | 32'(match_at != 0 && n >= match_at);
            status_base = status_reads;
            send(BRAM_OP_POLL, BRAM_STATUS_OFFSET, 32'h1, mk, lat, d, e, nwr, nrd);
            checks++; if (nrd !== n) $display("FAIL poll_reads got %0d want %0d", nrd, n); else passed++;
            checks++; if (lat !== n + 1) $display("FAIL poll_lat got %0d want %0d", lat, n + 1); else passed++;
            checks++; if (d !== want_d) $display("FAIL poll_data got %h want %h", d, want_d); else passed++;
            checks++; if (e !== !hit) $display("FAIL poll_err got %b want %b", e, !hit); else passed++;
            checks++; if (nwr !== 0) $display("FAIL poll_wr got %0d want 0", nwr); else passed++;
        end
    endtask
`endif

    task automatic test_reset_mid();
        int n, seen;
`ifdef BRAM_REG_MASTER_POLL_EN
        match_at = 0;
        status_base = status_reads;
        issue(BRAM_OP_POLL, BRAM_STATUS_OFFSET, 32'h1, 32'h1);
        n = 0;
        while (!(rd_en && status_reads - status_base == 2) && n < 50) begin
            @(negedge clk);
            n++;
        end
`else
        issue(BRAM_OP_READ, BRAM_ID_OFFSET, 32'h0, 32'h0);
        @(negedge clk);
`endif
        reset_n = 1'b0;
        #1;
        checks++; if ({wr_en, rd_en, resp_valid, busy, resp_err} !== 5'b0)
            $display("FAIL rst_mid_out got %b want 00000", {wr_en, rd_en, resp_valid, busy, resp_err});
        else passed++;
        checks++; if (reg_addr !== '0) $display("FAIL rst_mid_addr got %h want 0", reg_addr); else passed++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid || rd_en || wr_en) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL rst_mid_stale got %0d want 0", seen); else passed++;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_mid_ready got %b want 1", cmd_ready); else passed++;
    endtask

    task automatic test_back_to_back();
        int lat, nwr, nrd;
        logic [31:0] d, wd;
        logic e;
        logic [AW-1:0] a;
        for (int i = 0; i < 4; i++) begin
            a  = AW'($urandom_range(16, (1<<AW)-1));
            wd = $urandom;
            send(BRAM_OP_WRITE, a, wd, 32'h0, lat, d, e, nwr, nrd);
            model_mem[int'(a)] = wd;
            send(BRAM_OP_READ, a, 32'h0, 32'h0, lat, d, e, nwr, nrd);
            checks++; if (d !== model_mem[int'(a)])
                $display("FAIL b2b_data got %h want %h", d, model_mem[int'(a)]); else passed++;
        end
        checks++; if (both_cnt !== 0) $display("FAIL strobe_overlap got %0d want 0", both_cnt); else passed++;
    endtask

    initial begin
        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0;
        cmd_wdata = 32'h0; cmd_mask = 32'h0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        test_write();
        test_read();
        test_illegal();
        test_backpressure();
`ifdef BRAM_REG_MASTER_POLL_EN
        test_poll();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
